// File: rtl/pma_comma_align.sv
// Receive PMA word aligner: finds the 7-bit comma at any of 10 bit offsets, confirms it, locks, and emits aligned code-groups.
// Optional COMMA_ALIGN_STATS_EN adds a saturating realign_count output that counts lock losses.
module pma_comma_align #(
  parameter int CONFIRM_COUNT  = 3,
  parameter int MISALIGN_LIMIT = 2
) (
  input  logic       RX_CLK,
  input  logic       mr_main_reset,
  input  logic [9:0] raw_code_group,
  input  logic       raw_valid,
  output logic [9:0] rx_code_group,
  output logic       code_group_valid,
  output logic       comma_aligned,
  output logic [3:0] align_offset,
  output logic       comma_det
`ifdef COMMA_ALIGN_STATS_EN
  ,
  output logic [7:0] realign_count
`endif
);

  localparam logic [3:0] CONFIRM_LIM = 4'(CONFIRM_COUNT);
  localparam logic [3:0] MISS_LIM    = 4'(MISALIGN_LIMIT);

  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt, miss, miss_nxt, off_nxt;
  logic [9:0]  prev_p0;
  logic [19:0] win_p0;
  logic [15:0] hits;
  logic        hit_any;
  logic [3:0]  hit_k;
  logic [9:0]  emit_word;
  logic        drop;

  function automatic logic is_comma(input logic [6:0] w);
    return (w == 7'b1111100) || (w == 7'b0000011);
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign win_p0 = {raw_code_group, prev_p0};

  // Descending scan so the lowest matching offset is the one that sticks.
  always_comb begin
    hits    = '0;
    hit_any = 1'b0;
    hit_k   = '0;
    for (int k = 9; k >= 0; k--) begin
      if (is_comma(win_p0[k +: 7])) begin
        hits[k] = 1'b1;
        hit_any = 1'b1;
        hit_k   = 4'(k);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    miss_nxt  = miss;
    off_nxt   = align_offset;
    drop      = 1'b0;
    if (raw_valid) begin
      case (state)
        HUNT: begin
          if (hit_any) begin
            off_nxt   = hit_k;
            cnt_nxt   = 4'd1;
            miss_nxt  = '0;
            state_nxt = (CONFIRM_LIM <= 4'd1) ? LOCKED : CONFIRM;
          end
        end
        CONFIRM: begin
          if (hits[align_offset]) begin
            cnt_nxt = sat_inc4(cnt);
            if (sat_inc4(cnt) >= CONFIRM_LIM) begin
              state_nxt = LOCKED;
              miss_nxt  = '0;
            end
          end else if (hit_any) begin
            off_nxt = hit_k;
            cnt_nxt = 4'd1;
          end
        end
        LOCKED: begin
          if (hits[align_offset]) begin
            miss_nxt = '0;
          end else if (hit_any) begin
            miss_nxt = sat_inc4(miss);
            if (sat_inc4(miss) >= MISS_LIM) begin
              state_nxt = HUNT;
              cnt_nxt   = '0;
              miss_nxt  = '0;
              drop      = 1'b1;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // The emitted word uses the offset as updated by this same word.
  always_comb begin
    emit_word = win_p0[9:0];
    for (int k = 0; k < 10; k++) begin
      if (off_nxt == 4'(k)) emit_word = win_p0[k +: 10];
    end
  end

  always_ff @(posedge RX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state            <= HUNT;
      cnt              <= '0;
      miss             <= '0;
      align_offset     <= '0;
      prev_p0          <= '0;
      rx_code_group    <= '0;
      code_group_valid <= 1'b0;
      comma_det        <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      miss             <= miss_nxt;
      align_offset     <= off_nxt;
      code_group_valid <= 1'b0;
      if (raw_valid) begin
        prev_p0          <= raw_code_group;
        rx_code_group    <= emit_word;
        code_group_valid <= (state_nxt == LOCKED);
        comma_det        <= is_comma(emit_word[6:0]);
      end
    end
  end

  assign comma_aligned = (state == LOCKED);

`ifdef COMMA_ALIGN_STATS_EN
  always_ff @(posedge RX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      realign_count <= '0;
    end else if (drop && (realign_count != 8'hFF)) begin
      realign_count <= realign_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pma_comma_align.sv
// Directed-vector bench for pma_comma_align: aligned, shifted, interrupted-confirm, misalign-drop, idle-gap and reset cases.
module tb_pma_comma_align;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] raw;
  logic       vld;
  logic [9:0] rx;
  logic       cgv;
  logic       al;
  logic [3:0] off;
  logic       det;
`ifdef COMMA_ALIGN_STATS_EN
  logic [7:0] rc;
`endif

  always #5 clk = ~clk;

  pma_comma_align dut (
    .RX_CLK          (clk),
    .mr_main_reset   (rst_n),
    .raw_code_group  (raw),
    .raw_valid       (vld),
    .rx_code_group   (rx),
    .code_group_valid(cgv),
    .comma_aligned   (al),
    .align_offset    (off),
    .comma_det       (det)
`ifdef COMMA_ALIGN_STATS_EN
    ,
    .realign_count   (rc)
`endif
  );

  typedef struct {
    logic       rst;
    logic [9:0] raw;
    logic       vld;
    logic [9:0] rx;
    logic       cgv;
    logic       al;
    logic [3:0] off;
    logic       det;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(input logic r, input logic [9:0] rw, input logic v,
                              input logic [9:0] x, input logic c, input logic a,
                              input logic [3:0] o, input logic d);
    vec_t t;
    t.rst = r; t.raw = rw; t.vld = v;
    t.rx = x; t.cgv = c; t.al = a; t.off = o; t.det = d;
    vecs.push_back(t);
  endfunction

  task automatic check_zero(input string name);
    n_vec++;
    if ({rx, cgv, al, off, det} !== 17'd0) begin
      n_bad++;
      $display("FAIL %s: got rx=%h cgv=%b al=%b off=%0d det=%b, want all zero",
               name, rx, cgv, al, off, det);
    end
`ifdef COMMA_ALIGN_STATS_EN
    n_vec++;
    if (rc !== 8'd0) begin
      n_bad++;
      $display("FAIL %s realign_count: got %0d, want 0", name, rc);
    end
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    raw   = '0;
    vld   = 1'b0;
    #2;
    check_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    raw   = '0;
    vld   = 1'b0;

    // Aligned K28.5 stream, then idle gaps while locked
    add(1, 10'h17C, 1, 10'h000, 0, 0, 0, 0);
    add(0, 10'h283, 1, 10'h17C, 0, 0, 0, 1);
    add(0, 10'h17C, 1, 10'h283, 0, 0, 0, 1);
    add(0, 10'h283, 1, 10'h17C, 1, 1, 0, 1);
    add(0, 10'h17C, 1, 10'h283, 1, 1, 0, 1);
    add(0, 10'h283, 1, 10'h17C, 1, 1, 0, 1);
    add(0, 10'h3FF, 0, 10'h17C, 0, 1, 0, 1);
    add(0, 10'h17C, 1, 10'h283, 1, 1, 0, 1);
    add(0, 10'h000, 0, 10'h283, 0, 1, 0, 1);
    add(0, 10'h283, 1, 10'h17C, 1, 1, 0, 1);
    // Two commas at offset 0, then offset-5 stream restarts the candidate
    add(1, 10'h17C, 1, 10'h000, 0, 0, 0, 0);
    add(0, 10'h283, 1, 10'h17C, 0, 0, 0, 1);
    add(0, 10'h394, 1, 10'h283, 0, 0, 0, 1);
    add(0, 10'h06B, 1, 10'h17C, 0, 0, 5, 1);
    add(0, 10'h394, 1, 10'h283, 0, 0, 5, 1);
    add(0, 10'h06B, 1, 10'h17C, 1, 1, 5, 1);
    // Stream shifted by 3 bits, with an idle cycle just before the confirming word
    add(1, 10'h3E5, 1, 10'h000, 0, 0, 0, 0);
    add(0, 10'h01A, 1, 10'h17C, 0, 0, 3, 1);
    add(0, 10'h3E5, 1, 10'h283, 0, 0, 3, 1);
    add(0, 10'h01A, 0, 10'h283, 0, 0, 3, 1);
    add(0, 10'h01A, 1, 10'h17C, 1, 1, 3, 1);
    add(0, 10'h3E5, 1, 10'h283, 1, 1, 3, 1);
    add(0, 10'h01A, 1, 10'h17C, 1, 1, 3, 1);
    // Switch to an offset-7 stream: two foreign commas drop lock, three relock at 7
    add(0, 10'h250, 1, 10'h003, 1, 1, 3, 1);
    add(0, 10'h1AF, 1, 10'h3CA, 1, 1, 3, 0);
    add(0, 10'h250, 1, 10'h035, 0, 0, 3, 0);
    add(0, 10'h1AF, 1, 10'h17C, 0, 0, 7, 1);
    add(0, 10'h250, 1, 10'h283, 0, 0, 7, 1);
    add(0, 10'h1AF, 1, 10'h17C, 1, 1, 7, 1);
    add(0, 10'h250, 1, 10'h283, 1, 1, 7, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      @(negedge clk);
      raw = vecs[i].raw;
      vld = vecs[i].vld;
      @(posedge clk);
      #1;
      n_vec++;
      if ({rx, cgv, al, off, det} !==
          {vecs[i].rx, vecs[i].cgv, vecs[i].al, vecs[i].off, vecs[i].det}) begin
        n_bad++;
        $display("FAIL vec%0d: got rx=%h cgv=%b al=%b off=%0d det=%b, want rx=%h cgv=%b al=%b off=%0d det=%b",
                 i, rx, cgv, al, off, det,
                 vecs[i].rx, vecs[i].cgv, vecs[i].al, vecs[i].off, vecs[i].det);
      end
    end

`ifdef COMMA_ALIGN_STATS_EN
    n_vec++;
    if (rc !== 8'd1) begin
      n_bad++;
      $display("FAIL realign_count_after_drop: got %0d, want 1", rc);
    end
`endif

    // Reset asserted between clock edges while locked must clear outputs at once
    @(negedge clk);
    raw = 10'h17C;
    vld = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset_locked");
    #10;
    rst_n = 1'b1;
    vld   = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
